rr_mux_array: RTL and testbench

N-channel, WIDTH-bit registered multiplexer with round-robin arbitration and a valid/ready handshake on every port. It generalises the 2:1 combinational mux array: several producers compete for one shared 16-bit datapath, such as the register-file write port or the memory-bus master port. One winner per cycle is forwarded through a single output register, with fair rotation and no starvation.

---
 rtl/rr_mux_array_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/rr_mux_array.sv | 91 +++++++++
 tb/tb_rr_mux_array.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_array_pkg.sv
// Shared constants for the round-robin mux array: default word width and index-width helper.
package rr_mux_array_pkg;

  localparam int unsigned DefaultWidth = 16;

  // Index width for n channels; never below 1 so a single channel still has a port bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward with wrap, first valid channel wins.
module rr_arbiter
  import rr_mux_array_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned IDXW = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [IDXW-1:0]     ptr,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [IDXW-1:0]     grant_idx,
  output logic                any
);

  logic [2*CHANNELS-1:0] dbl;
  logic [2*CHANNELS-1:0] rot;
  logic                  found;
  int unsigned           win;

  // Doubled request vector shifted by ptr turns the wrap-around scan into a plain LSB-first scan.
  always_comb begin
    dbl   = {in_valid, in_valid};
    rot   = dbl >> ptr;
    found = 1'b0;
    win   = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        win   = 32'(ptr) + i;
        if (win >= CHANNELS) begin
          win = win - CHANNELS;
        end
      end
    end
  end

  // Decode the winning index into the one-hot grant, gated by the enable.
  always_comb begin
    grant     = '0;
    grant_idx = IDXW'(win);
    any       = found && en;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      grant[j] = any && (j == win);
    end
  end

endmodule

// File: rtl/rr_mux_array.sv
// N-channel registered mux with round-robin arbitration and valid/ready on every port.
module rr_mux_array
  import rr_mux_array_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned IDXW    = idx_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDXW-1:0]           out_chan,
  input  logic                      out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IDXW-1:0]  out_chan_q;
  logic [IDXW-1:0]  ptr_q;
  logic [IDXW-1:0]  ptr_d;

  logic                load;
  logic                arb_en;
  logic [CHANNELS-1:0] grant;
  logic [IDXW-1:0]     grant_idx;
  logic                transfer;
  logic [WIDTH-1:0]    sel_data;

  // Register may take a new word when empty or being drained this cycle; never during reset.
  assign load   = !out_valid_q || out_ready;
  assign arb_en = load && rst_n;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arbiter (
    .in_valid  (in_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (transfer)
  );

  assign in_ready = grant;

  // AND-OR data select over the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Next pointer is one past the winner, wrapping after the last channel.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      if (grant_idx == IDXW'(CHANNELS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + IDXW'(1);
      end
    end
  end

  // Output register and pointer: load on transfer, drain on idle load, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_chan_q  <= grant_idx;
      ptr_q       <= ptr_d;
    end else if (load) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_mux_array.sv
// Directed self-checking bench for rr_mux_array, including 1/3/16-channel instances.
module tb_rr_mux_array;

  logic clk;
  logic rst_n;

  // Main instance: 4 channels x 16 bits
  logic [3:0]  in_valid4;
  logic [63:0] in_data4;
  logic [3:0]  in_ready4;
  logic        out_valid4;
  logic [15:0] out_data4;
  logic [1:0]  out_chan4;
  logic        out_ready4;

  // 3 channels x 8 bits
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_ready3;

  // 1 channel x 32 bits
  logic [0:0]  in_valid1;
  logic [31:0] in_data1;
  logic [0:0]  in_ready1;
  logic        out_valid1;
  logic [31:0] out_data1;
  logic [0:0]  out_chan1;
  logic        out_ready1;

  // 16 channels x 8 bits
  logic [15:0]  in_valid16;
  logic [127:0] in_data16;
  logic [15:0]  in_ready16;
  logic         out_valid16;
  logic [7:0]   out_data16;
  logic [3:0]   out_chan16;
  logic         out_ready16;

  int n_checks;
  int n_fail;

  rr_mux_array #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid4), .in_data (in_data4), .in_ready (in_ready4),
    .out_valid (out_valid4), .out_data (out_data4), .out_chan (out_chan4),
    .out_ready (out_ready4)
  );

  rr_mux_array #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid3), .in_data (in_data3), .in_ready (in_ready3),
    .out_valid (out_valid3), .out_data (out_data3), .out_chan (out_chan3),
    .out_ready (out_ready3)
  );

  rr_mux_array #(.WIDTH(32), .CHANNELS(1)) dut1 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid1), .in_data (in_data1), .in_ready (in_ready1),
    .out_valid (out_valid1), .out_data (out_data1), .out_chan (out_chan1),
    .out_ready (out_ready1)
  );

  rr_mux_array #(.WIDTH(8), .CHANNELS(16)) dut16 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid16), .in_data (in_data16), .in_ready (in_ready16),
    .out_valid (out_valid16), .out_data (out_data16), .out_chan (out_chan16),
    .out_ready (out_ready16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid4  = 4'hF;
    in_data4   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    out_ready4 = 1'b1;
    #1;
    n_checks++;
    if (out_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid4);
    end
    n_checks++;
    if (out_data4 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data4);
    end
    n_checks++;
    if (in_ready4 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0001) begin
      n_fail++; $display("FAIL post_reset_in_ready: got %b expected 0001", in_ready4);
    end
    step();
    n_checks++;
    if (out_valid4 !== 1'b1 || out_data4 !== 16'h1111 || out_chan4 !== 2'd0) begin
      n_fail++;
      $display("FAIL first_load: got v=%b d=%h c=%0d expected v=1 d=1111 c=0",
               out_valid4, out_data4, out_chan4);
    end
    // Asynchronous reset while holding a word
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid4 !== 1'b0 || out_data4 !== 16'h0000 || out_chan4 !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset_regs: got v=%b d=%h c=%0d expected v=0 d=0000 c=0",
               out_valid4, out_data4, out_chan4);
    end
    n_checks++;
    if (in_ready4 !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_in_ready: got %b expected 0000", in_ready4);
    end
    in_valid4 = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0010) begin
      n_fail++; $display("FAIL release_in_ready: got %b expected 0010", in_ready4);
    end
    step();
    n_checks++;
    if (out_valid4 !== 1'b1 || out_chan4 !== 2'd1 || out_data4 !== 16'h2222) begin
      n_fail++;
      $display("FAIL release_grant: got v=%b c=%0d d=%h expected v=1 c=1 d=2222",
               out_valid4, out_chan4, out_data4);
    end
    in_valid4 = 4'b0000;
  endtask

  task automatic test_rotation();
    logic [15:0] exp_data [4];
    exp_data[0] = 16'h1111;
    exp_data[1] = 16'h2222;
    exp_data[2] = 16'h3333;
    exp_data[3] = 16'h4444;
    in_valid4 = 4'b0000;
    do_reset();
    in_data4   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    in_valid4  = 4'hF;
    out_ready4 = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (in_ready4 !== (4'b0001 << (k % 4))) begin
        n_fail++;
        $display("FAIL rot_in_ready[%0d]: got %b expected %b", k, in_ready4,
                 4'b0001 << (k % 4));
      end
      step();
      n_checks++;
      if (out_valid4 !== 1'b1 || out_chan4 !== 2'(k % 4) || out_data4 !== exp_data[k % 4]) begin
        n_fail++;
        $display("FAIL rot_out[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h", k,
                 out_valid4, out_chan4, out_data4, k % 4, exp_data[k % 4]);
      end
      #1;
    end
    in_valid4 = 4'b0000;
  endtask

  task automatic test_backpressure();
    in_valid4 = 4'b0000;
    do_reset();
    in_data4   = {16'h0000, 16'h0000, 16'hCAFE, 16'hBEEF};
    in_valid4  = 4'b0001;
    out_ready4 = 1'b1;
    step();
    n_checks++;
    if (out_valid4 !== 1'b1 || out_data4 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL bp_fill: got v=%b d=%h expected v=1 d=BEEF", out_valid4, out_data4);
    end
    out_ready4 = 1'b0;
    in_valid4  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (in_ready4 !== 4'b0000) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, in_ready4);
      end
      step();
      n_checks++;
      if (out_valid4 !== 1'b1 || out_data4 !== 16'hBEEF || out_chan4 !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d expected v=1 d=BEEF c=0", k,
                 out_valid4, out_data4, out_chan4);
      end
    end
    out_ready4 = 1'b1;
    #1;
    n_checks++;
    if (in_ready4 !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready4);
    end
    step();
    n_checks++;
    if (out_valid4 !== 1'b1 || out_data4 !== 16'hCAFE || out_chan4 !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_release_load: got v=%b d=%h c=%0d expected v=1 d=CAFE c=1",
               out_valid4, out_data4, out_chan4);
    end
    in_valid4 = 4'b0000;
  endtask

  task automatic test_wrap_skip_and_drain();
    logic [1:0] exp_chan [3];
    exp_chan[0] = 2'd0;
    exp_chan[1] = 2'd2;
    exp_chan[2] = 2'd0;
    in_valid4 = 4'b0000;
    do_reset();
    in_data4   = {16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0};
    out_ready4 = 1'b1;
    in_valid4  = 4'b0100;
    step();
    n_checks++;
    if (out_chan4 !== 2'd2) begin
      n_fail++; $display("FAIL wrap_setup: got c=%0d expected c=2", out_chan4);
    end
    // Pointer now sits at 3
    in_valid4 = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (out_chan4 !== exp_chan[k] ||
          out_data4 !== (exp_chan[k] == 2'd0 ? 16'hA0A0 : 16'hA2A2)) begin
        n_fail++;
        $display("FAIL wrap_skip[%0d]: got c=%0d d=%h expected c=%0d", k, out_chan4,
                 out_data4, exp_chan[k]);
      end
    end
    // Idle drain: pointer should stay at 1
    in_valid4 = 4'b0000;
    step();
    n_checks++;
    if (out_valid4 !== 1'b0 || out_data4 !== 16'hA0A0 || out_chan4 !== 2'd0) begin
      n_fail++;
      $display("FAIL drain: got v=%b d=%h c=%0d expected v=0 d=A0A0 c=0",
               out_valid4, out_data4, out_chan4);
    end
    step();
    n_checks++;
    if (out_valid4 !== 1'b0 || out_data4 !== 16'hA0A0) begin
      n_fail++;
      $display("FAIL drain_idle: got v=%b d=%h expected v=0 d=A0A0", out_valid4, out_data4);
    end
    in_valid4 = 4'hF;
    step();
    n_checks++;
    if (out_valid4 !== 1'b1 || out_chan4 !== 2'd1 || out_data4 !== 16'hA1A1) begin
      n_fail++;
      $display("FAIL drain_ptr_kept: got v=%b c=%0d d=%h expected v=1 c=1 d=A1A1",
               out_valid4, out_chan4, out_data4);
    end
    in_valid4 = 4'b0000;
  endtask

  task automatic test_param_sweep();
    in_valid3  = '0;
    in_valid1  = '0;
    in_valid16 = '0;
    do_reset();
    for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 16; i++) in_data16[i*8 +: 8] = 8'(i * 17);
    in_data1    = 32'hDEAD0000;
    in_valid3   = 3'b111;
    in_valid1   = 1'b1;
    in_valid16  = 16'hFFFF;
    out_ready3  = 1'b1;
    out_ready1  = 1'b1;
    out_ready16 = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (in_ready3 !== (3'b001 << (k % 3))) begin
        n_fail++;
        $display("FAIL c3_in_ready[%0d]: got %b expected %b", k, in_ready3, 3'b001 << (k % 3));
      end
      n_checks++;
      if (in_ready16 !== (16'h0001 << (k % 16))) begin
        n_fail++;
        $display("FAIL c16_in_ready[%0d]: got %h expected %h", k, in_ready16,
                 16'h0001 << (k % 16));
      end
      step();
      n_checks++;
      if (out_valid3 !== 1'b1 || out_chan3 !== 2'(k % 3) || out_data3 !== 8'(8'h10 + k % 3)) begin
        n_fail++;
        $display("FAIL c3_out[%0d]: got v=%b c=%0d d=%h expected c=%0d", k,
                 out_valid3, out_chan3, out_data3, k % 3);
      end
      n_checks++;
      if (out_valid1 !== 1'b1 || out_chan1 !== 1'b0 || out_data1 !== 32'hDEAD0000 + 32'(k)) begin
        n_fail++;
        $display("FAIL c1_out[%0d]: got v=%b c=%0d d=%h expected d=%h", k,
                 out_valid1, out_chan1, out_data1, 32'hDEAD0000 + 32'(k));
      end
      n_checks++;
      if (out_valid16 !== 1'b1 || out_chan16 !== 4'(k % 16) ||
          out_data16 !== 8'((k % 16) * 17)) begin
        n_fail++;
        $display("FAIL c16_out[%0d]: got v=%b c=%0d d=%h expected c=%0d", k,
                 out_valid16, out_chan16, out_data16, k % 16);
      end
      // Single channel is accepted every cycle, so its data may advance each cycle
      in_data1 = 32'hDEAD0000 + 32'(k + 1);
      #1;
    end
    in_valid3  = '0;
    in_valid1  = '0;
    in_valid16 = '0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    in_valid3   = '0;
    in_data3    = '0;
    out_ready3  = 1'b1;
    in_valid1   = '0;
    in_data1    = '0;
    out_ready1  = 1'b1;
    in_valid16  = '0;
    in_data16   = '0;
    out_ready16 = 1'b1;
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap_skip_and_drain();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
